// File: rtl/mem_dot_engine_if.sv
// Bundle of the job-request, memory-port and result-handshake signals of the dot-product engine.
// The engine sits on the slave side; the host/memory/consumer side drives the master modport.
interface mem_dot_engine_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
);
    logic              start;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_hold;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [ACC_W-1:0]  result;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output start, base_a, base_b, len, mem_rdata, res_ready,
        input  mem_addr, mem_en, mem_hold, busy, result, res_valid
    );

    modport slave (
        input  start, base_a, base_b, len, mem_rdata, res_ready,
        output mem_addr, mem_en, mem_hold, busy, result, res_valid
    );
endinterface

// File: rtl/mem_dot_engine.sv
// Reads two signed vectors from a 64x32 async-read memory, accumulates their dot product
// and offers the 64-bit result over a valid/ready handshake, freezing memory writes while busy.
module mem_dot_engine #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic            clka,
    input  logic            rst_n,
    mem_dot_engine_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_A = 2'd1,
        FETCH_B = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_a_reg, base_a_next;
    logic [ADDR_W-1:0] base_b_reg, base_b_next;
    logic [ADDR_W-1:0] len_reg, len_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] op_a_reg, op_a_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [ACC_W-1:0]  result_reg, result_next;

    logic [ADDR_W-1:0] idx_inc;
    logic [ACC_W-1:0]  op_a_ext;
    logic [ACC_W-1:0]  op_b_ext;
    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  acc_sum;

    // Sign-extend both operands to the accumulator width; the low ACC_W bits of the
    // unsigned product of the extended values equal the signed product.
    assign op_a_ext = {{(ACC_W-DATA_W){op_a_reg[DATA_W-1]}}, op_a_reg};
    assign op_b_ext = {{(ACC_W-DATA_W){bus.mem_rdata[DATA_W-1]}}, bus.mem_rdata};
    assign prod     = op_a_ext * op_b_ext;
    assign acc_sum  = acc_reg + prod;
    assign idx_inc  = idx_reg + ADDR_W'(1);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            base_a_reg <= '0;
            base_b_reg <= '0;
            len_reg    <= '0;
            idx_reg    <= '0;
            addr_reg   <= '0;
            op_a_reg   <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            base_a_reg <= base_a_next;
            base_b_reg <= base_b_next;
            len_reg    <= len_next;
            idx_reg    <= idx_next;
            addr_reg   <= addr_next;
            op_a_reg   <= op_a_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        base_a_next = base_a_reg;
        base_b_next = base_b_reg;
        len_next    = len_reg;
        idx_next    = idx_reg;
        addr_next   = addr_reg;
        op_a_next   = op_a_reg;
        acc_next    = acc_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    base_a_next = bus.base_a;
                    base_b_next = bus.base_b;
                    len_next    = bus.len;
                    idx_next    = '0;
                    acc_next    = '0;
                    if (bus.len == '0) begin
                        state_next  = DONE;
                        result_next = '0;
                    end else begin
                        state_next = FETCH_A;
                        addr_next  = bus.base_a;
                    end
                end
            end
            FETCH_A: begin
                op_a_next  = bus.mem_rdata;
                addr_next  = base_b_reg + idx_reg;
                state_next = FETCH_B;
            end
            FETCH_B: begin
                acc_next = acc_sum;
                idx_next = idx_inc;
                if (idx_inc == len_reg) begin
                    state_next  = DONE;
                    result_next = acc_sum;
                end else begin
                    state_next = FETCH_A;
                    addr_next  = base_a_reg + idx_inc;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_reg;
    assign bus.mem_en    = (state_reg == FETCH_A) || (state_reg == FETCH_B);
    assign bus.mem_hold  = (state_reg != IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.res_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
endmodule

// File: tb/tb_mem_dot_engine.sv
// Directed and randomized jobs against a behavioural dot-product model over a 64-word memory image.
module tb_mem_dot_engine;
    logic clka = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] mem [64];
    logic [5:0]  addr_q [$];
    int n_assert = 0;
    int n_fail   = 0;

    mem_dot_engine_if #(.ADDR_W(6), .DATA_W(32), .ACC_W(64)) bus ();

    mem_dot_engine #(.ADDR_W(6), .DATA_W(32), .ACC_W(64)) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clka = ~clka;

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Record every address presented while the engine fetches.
    always @(negedge clka) begin
        if (bus.mem_en) addr_q.push_back(bus.mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_dot(input int ba, input int bb, input int ln);
        longint acc = 0;
        for (int i = 0; i < ln; i++)
            acc += longint'($signed(mem[(ba + i) % 64])) * longint'($signed(mem[(bb + i) % 64]));
        return acc;
    endfunction

    // Launch a job and wait for res_valid; returns edges counted from the start-sampling edge.
    task automatic launch(input int ba, input int bb, input int ln, output int edges);
        @(negedge clka);
        addr_q.delete();
        bus.start  = 1'b1;
        bus.base_a = 6'(ba);
        bus.base_b = 6'(bb);
        bus.len    = 6'(ln);
        @(posedge clka);
        #1;
        bus.start = 1'b0;
        edges = 1;
        while (!bus.res_valid && edges < 200) begin
            @(posedge clka);
            #1;
            edges++;
        end
    endtask

    task automatic release_result();
        @(negedge clka);
        bus.res_ready = 1'b1;
        @(posedge clka);
        #1;
        bus.res_ready = 1'b0;
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_valid", 64'(bus.res_valid), 64'd0);
    endtask

    task automatic full_job(input string tag, input int ba, input int bb, input int ln);
        int edges;
        logic [63:0] exp;
        exp = model_dot(ba, bb, ln);
        launch(ba, bb, ln, edges);
        check({tag, "_latency"}, 64'(edges), 64'(2 * ln + 1));
        check({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_hold"}, 64'(bus.mem_hold), 64'd1);
        check({tag, "_fetches"}, 64'(addr_q.size()), 64'(2 * ln));
        release_result();
    endtask

    initial begin
        int edges;
        logic [63:0] r;
        bus.start = 1'b0; bus.base_a = '0; bus.base_b = '0; bus.len = '0; bus.res_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;

        #12;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_valid", 64'(bus.res_valid), 64'd0);
        check("reset_result", bus.result, 64'd0);
        check("reset_en_hold", {62'd0, bus.mem_en, bus.mem_hold}, 64'd0);
        @(negedge clka);
        rst_n = 1'b1;

        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        mem[8] = 5; mem[9] = 6; mem[10] = 7; mem[11] = 8;
        launch(0, 8, 4, edges);
        check("t1_latency", 64'(edges), 64'd9);
        check("t1_result", bus.result, 64'd70);
        release_result();

        mem[5] = 32'hFFFF_FFFF; mem[6] = 32'd3;
        full_job("t2", 5, 6, 1);
        check("t2_const", bus.result, 64'hFFFF_FFFF_FFFF_FFFD);

        full_job("t3", 0, 8, 0);
        check("t3_const", bus.result, 64'd0);

        mem[62] = 32'h8000_0000; mem[63] = 32'h7FFF_FFFF; mem[0] = 32'hFFFF_FFF9;
        mem[20] = 32'h8000_0000; mem[21] = 32'hFFFF_FFFE; mem[22] = 32'd11;
        full_job("t4", 62, 20, 3);
        check("t4_addr0", 64'(addr_q[0]), 64'd62);
        check("t4_addr2", 64'(addr_q[2]), 64'd63);
        check("t4_addr4", 64'(addr_q[4]), 64'd0);
        check("t4_addrb", 64'(addr_q[5]), 64'd22);

        launch(0, 8, 4, edges);
        r = bus.result;
        check("t5_result", r, model_dot(0, 8, 4));
        for (int k = 0; k < 5; k++) begin
            @(negedge clka);
            bus.start = 1'b1; bus.base_a = 6'd5; bus.base_b = 6'd6; bus.len = 6'd1;
            @(posedge clka);
            #1;
            bus.start = 1'b0;
            check("t5_stable_valid", 64'(bus.res_valid), 64'd1);
            check("t5_stable_result", bus.result, r);
        end
        release_result();

        launch(0, 8, 0, edges);
        release_result();
        @(negedge clka);
        bus.start = 1'b1; bus.base_a = 6'd0; bus.base_b = 6'd8; bus.len = 6'd4;
        @(posedge clka);
        #1;
        bus.start = 1'b0;
        @(posedge clka);
        #2;
        check("t6_pre_en", 64'(bus.mem_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_en_hold_valid", {61'd0, bus.mem_en, bus.mem_hold, bus.res_valid}, 64'd0);
        check("t6_addr", 64'(bus.mem_addr), 64'd0);
        check("t6_result", bus.result, 64'd0);
        @(negedge clka);
        rst_n = 1'b1;
        full_job("t6_after", 0, 8, 4);

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int j = 0; j < 12; j++) begin
            int ba, bb, ln;
            ba = int'($urandom_range(0, 63));
            bb = (j % 3 == 0) ? ba : int'($urandom_range(0, 63));
            ln = (j == 1) ? 63 : int'($urandom_range(0, 63));
            full_job("rand", ba, bb, ln);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
